branch_resolver: RTL and testbench

Registered branch-resolution stage of the RISC-V core, directly downstream of the comparison flag units in `processor/flags`. It consumes the equal, unsigned-greater and signed-greater flags for a conditional branch, decodes `funct3`, and computes taken/not-taken, the branch target and the next PC. Results are held in a one-entry output register behind a valid/ready handshake. Per-branch statistics counters are included.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/branch_cond.sv | 28 ++
 rtl/branch_resolver.sv | 80 ++++++++
 tb/tb_branch_resolver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: branch funct3 encodings and instruction length.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int INSTR_LEN = 4;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decode from funct3 and comparison flags.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       flag_equal,
    input  logic       flag_greater,
    input  logic       flag_greater_signed,
    output logic       taken,
    output logic       illegal
);

    // Less-than is derived as "neither equal nor greater" since only eq/gt flags exist.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = flag_equal;
            F3_BNE:  taken = !flag_equal;
            F3_BLT:  taken = !flag_equal && !flag_greater_signed;
            F3_BGE:  taken = flag_equal || flag_greater_signed;
            F3_BLTU: taken = !flag_equal && !flag_greater;
            F3_BGEU: taken = flag_equal || flag_greater;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Registered branch resolution stage: condition, target, next PC and statistics
// held in a one-entry output register behind a valid/ready handshake.
module branch_resolver
    import riscv_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int CNTWIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          funct3,
    input  logic                flag_equal,
    input  logic                flag_greater,
    input  logic                flag_greater_signed,
    input  logic [WORDSIZE-1:0] pc,
    input  logic [WORDSIZE-1:0] imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                taken,
    output logic [WORDSIZE-1:0] target,
    output logic [WORDSIZE-1:0] next_pc,
    output logic                misaligned,
    output logic                illegal,
    output logic [CNTWIDTH-1:0] branch_count,
    output logic [CNTWIDTH-1:0] taken_count
);

    logic                condTaken;
    logic                condIllegal;
    logic [WORDSIZE-1:0] sumTarget;
    logic [WORDSIZE-1:0] seqPc;
    logic                accept;

    branch_cond u_cond (
        .funct3              (funct3),
        .flag_equal          (flag_equal),
        .flag_greater        (flag_greater),
        .flag_greater_signed (flag_greater_signed),
        .taken               (condTaken),
        .illegal             (condIllegal)
    );

    assign sumTarget = pc + imm;
    assign seqPc     = pc + WORDSIZE'(INSTR_LEN);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !flush;

    // Reset beats flush beats accept/drain; a drain with a same-cycle accept reloads without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            taken        <= 1'b0;
            target       <= '0;
            next_pc      <= '0;
            misaligned   <= 1'b0;
            illegal      <= 1'b0;
            branch_count <= '0;
            taken_count  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            taken        <= condTaken;
            target       <= sumTarget;
            next_pc      <= condTaken ? sumTarget : seqPc;
            misaligned   <= condTaken && (sumTarget[1:0] != 2'b00);
            illegal      <= condIllegal;
            branch_count <= branch_count + 1'b1;
            if (condTaken) begin
                taken_count <= taken_count + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: vector table plus handshake/flush/reset sequences.
module tb_branch_resolver;

    localparam int W = 64;
    localparam int C = 32;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]    funct3;
    logic          flag_equal, flag_greater, flag_greater_signed;
    logic [W-1:0]  pc, imm, target, next_pc;
    logic          taken, misaligned, illegal;
    logic [C-1:0]  branch_count, taken_count;

    int passCount = 0;
    int totalCount = 0;
    int expBranch = 0;
    int expTaken = 0;

    typedef struct {
        logic [2:0]   f3;
        logic         eq, g, gs;
        logic [W-1:0] pcV, immV;
        logic         expTk;
        logic [W-1:0] expTgt, expNpc;
        logic         expMis, expIll;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    branch_resolver #(.WORDSIZE(W), .CNTWIDTH(C)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .flag_equal(flag_equal), .flag_greater(flag_greater),
        .flag_greater_signed(flag_greater_signed),
        .pc(pc), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .taken(taken), .target(target), .next_pc(next_pc),
        .misaligned(misaligned), .illegal(illegal),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        funct3              = v.f3;
        flag_equal          = v.eq;
        flag_greater        = v.g;
        flag_greater_signed = v.gs;
        pc                  = v.pcV;
        imm                 = v.immV;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, " branch_count"}, W'(branch_count), W'(expBranch));
        checkOutput({tag, " taken_count"}, W'(taken_count), W'(expTaken));
    endtask

    initial begin
        vec_t v;
        // f3, eq, g, gs, pc, imm, taken, target, next_pc, misaligned, illegal
        vecs[0]  = '{3'b000, 1, 0, 0, 64'h1000, 64'h20, 1, 64'h1020, 64'h1020, 0, 0};
        vecs[1]  = '{3'b110, 0, 0, 1, 64'h2000, 64'h40, 1, 64'h2040, 64'h2040, 0, 0};
        vecs[2]  = '{3'b100, 0, 0, 1, 64'h2000, 64'h40, 0, 64'h2040, 64'h2004, 0, 0};
        vecs[3]  = '{3'b101, 0, 0, 1, 64'h2000, 64'h40, 1, 64'h2040, 64'h2040, 0, 0};
        vecs[4]  = '{3'b001, 1, 0, 0, 64'h3000, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h2FF8, 64'h3004, 0, 0};
        vecs[5]  = '{3'b111, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1, 64'h10, 64'h10, 0, 0};
        vecs[6]  = '{3'b000, 1, 0, 0, 64'h1000, 64'h6, 1, 64'h1006, 64'h1006, 1, 0};
        vecs[7]  = '{3'b000, 0, 0, 0, 64'h1000, 64'h6, 0, 64'h1006, 64'h1004, 0, 0};
        vecs[8]  = '{3'b010, 1, 1, 1, 64'h4000, 64'h10, 0, 64'h4010, 64'h4004, 0, 1};
        vecs[9]  = '{3'b110, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, 0};
        vecs[10] = '{3'b011, 1, 0, 0, 64'h4100, 64'h8, 0, 64'h4108, 64'h4104, 0, 1};
        vecs[11] = '{3'b001, 0, 0, 0, 64'h5000, 64'h4, 1, 64'h5004, 64'h5004, 0, 0};
        vecs[12] = '{3'b100, 0, 1, 0, 64'h6000, 64'h102, 1, 64'h6102, 64'h6102, 1, 0};

        reset = 1; flush = 0; in_valid = 0; out_ready = 1;
        applyStimulus(vecs[0]);
        tick(); tick();
        reset = 0;
        #1;
        checkOutput("reset out_valid", W'(out_valid), 0);
        checkOutput("reset taken", W'(taken), 0);
        checkOutput("reset target", target, 0);
        checkOutput("reset next_pc", next_pc, 0);
        checkOutput("reset misaligned", W'(misaligned), 0);
        checkOutput("reset illegal", W'(illegal), 0);
        checkCounts("reset");
        checkOutput("reset in_ready", W'(in_ready), 1);

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            applyStimulus(v);
            in_valid = 1;
            tick();
            in_valid = 0;
            expBranch++;
            if (v.expTk) expTaken++;
            checkOutput($sformatf("vec%0d out_valid", i), W'(out_valid), 1);
            checkOutput($sformatf("vec%0d taken", i), W'(taken), W'(v.expTk));
            checkOutput($sformatf("vec%0d target", i), target, v.expTgt);
            checkOutput($sformatf("vec%0d next_pc", i), next_pc, v.expNpc);
            checkOutput($sformatf("vec%0d misaligned", i), W'(misaligned), W'(v.expMis));
            checkOutput($sformatf("vec%0d illegal", i), W'(illegal), W'(v.expIll));
            checkCounts($sformatf("vec%0d", i));
        end
        tick();
        checkOutput("drain out_valid", W'(out_valid), 0);

        // Backpressure: first result held while second waits, then loads with no bubble
        out_ready = 0;
        v = '{3'b000, 1, 0, 0, 64'h100, 64'h8, 1, 64'h108, 64'h108, 0, 0};
        applyStimulus(v);
        in_valid = 1;
        tick();
        expBranch++; expTaken++;
        checkOutput("bp first out_valid", W'(out_valid), 1);
        checkOutput("bp in_ready low", W'(in_ready), 0);
        v = '{3'b001, 0, 0, 0, 64'h200, 64'h10, 1, 64'h210, 64'h210, 0, 0};
        applyStimulus(v);
        tick();
        tick();
        checkOutput("bp held target", target, 64'h108);
        checkOutput("bp held next_pc", next_pc, 64'h108);
        checkCounts("bp held");
        out_ready = 1;
        #1;
        checkOutput("bp in_ready high", W'(in_ready), 1);
        tick();
        in_valid = 0;
        expBranch++; expTaken++;
        checkOutput("bp second out_valid", W'(out_valid), 1);
        checkOutput("bp second target", target, 64'h210);
        checkCounts("bp second");
        tick();
        checkOutput("bp drained", W'(out_valid), 0);

        // Flush with a held result and a new branch offered
        out_ready = 0;
        v = '{3'b000, 1, 0, 0, 64'h700, 64'h4, 1, 64'h704, 64'h704, 0, 0};
        applyStimulus(v);
        in_valid = 1;
        tick();
        expBranch++; expTaken++;
        checkOutput("flush pre out_valid", W'(out_valid), 1);
        out_ready = 1;
        flush = 1;
        v = '{3'b000, 1, 0, 0, 64'h800, 64'h4, 1, 64'h804, 64'h804, 0, 0};
        applyStimulus(v);
        tick();
        flush = 0;
        in_valid = 0;
        checkOutput("flush out_valid", W'(out_valid), 0);
        checkCounts("flush");
        tick();
        checkOutput("flush stays empty", W'(out_valid), 0);

        // Reset mid-stream drops the held result and clears counters
        out_ready = 0;
        v = '{3'b101, 1, 0, 0, 64'h900, 64'h3, 1, 64'h903, 64'h903, 1, 0};
        applyStimulus(v);
        in_valid = 1;
        tick();
        checkOutput("prereset misaligned", W'(misaligned), 1);
        reset = 1;
        tick();
        reset = 0;
        in_valid = 0;
        out_ready = 1;
        expBranch = 0; expTaken = 0;
        checkOutput("midreset out_valid", W'(out_valid), 0);
        checkOutput("midreset taken", W'(taken), 0);
        checkOutput("midreset target", target, 0);
        checkOutput("midreset next_pc", next_pc, 0);
        checkOutput("midreset misaligned", W'(misaligned), 0);
        checkCounts("midreset");
        checkOutput("midreset in_ready", W'(in_ready), 1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
